// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one req/ack memory port between the IF and MEM
//                    stages, MEM-first with an IF starvation guard and timeout
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   output logic          if_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          d_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          err
);

   localparam int c_SW = $clog2(STARVE_LIMIT + 1);
   localparam int c_WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
   localparam logic [c_WW-1:0] c_WAIT_LAST  = c_WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GNT_IF = 2'd1,
      ST_GNT_D  = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [c_SW-1:0] r_starve_cnt, w_starve_nxt;
   logic [c_WW-1:0] r_wait_cnt, w_wait_nxt;

   logic            w_req_nxt, w_we_nxt, w_if_valid_nxt, w_d_valid_nxt, w_err_nxt;
   logic [AW-1:0]   w_addr_nxt;
   logic [DW-1:0]   w_wdata_nxt, w_if_rdata_nxt, w_d_rdata_nxt;
   logic            w_pick_d, w_pick_if, w_grant_d, w_grant_if;

   // The winner is chosen on raw requests; a winner whose valid is high is
   // still holding its just-completed request, so that cycle grants nobody.
   assign w_pick_d   = d_req & (~if_req | (r_starve_cnt < c_STARVE_MAX));
   assign w_pick_if  = if_req & ~w_pick_d;
   assign w_grant_d  = w_pick_d & ~d_valid;
   assign w_grant_if = w_pick_if & ~if_valid;

   assign if_stall = if_req & ~if_valid;
   assign d_stall  = d_req & ~d_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= '0;
         r_wait_cnt   <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         if_rdata     <= '0;
         d_rdata      <= '0;
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         err          <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_wait_cnt   <= w_wait_nxt;
         mem_req      <= w_req_nxt;
         mem_we       <= w_we_nxt;
         mem_addr     <= w_addr_nxt;
         mem_wdata    <= w_wdata_nxt;
         if_rdata     <= w_if_rdata_nxt;
         d_rdata      <= w_d_rdata_nxt;
         if_valid     <= w_if_valid_nxt;
         d_valid      <= w_d_valid_nxt;
         err          <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_starve_nxt   = r_starve_cnt;
      w_wait_nxt     = r_wait_cnt;
      w_req_nxt      = mem_req;
      w_we_nxt       = mem_we;
      w_addr_nxt     = mem_addr;
      w_wdata_nxt    = mem_wdata;
      w_if_rdata_nxt = if_rdata;
      w_d_rdata_nxt  = d_rdata;
      w_if_valid_nxt = 1'b0;
      w_d_valid_nxt  = 1'b0;
      w_err_nxt      = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_grant_d) begin
               w_state_nxt = ST_GNT_D;
               w_req_nxt   = 1'b1;
               w_we_nxt    = d_we;
               w_addr_nxt  = d_addr;
               w_wdata_nxt = d_wdata;
               w_wait_nxt  = '0;
               if (if_req && (r_starve_cnt != c_STARVE_MAX))
                  w_starve_nxt = r_starve_cnt + 1'b1;
            end else if (w_grant_if) begin
               w_state_nxt  = ST_GNT_IF;
               w_req_nxt    = 1'b1;
               w_we_nxt     = 1'b0;
               w_addr_nxt   = if_addr;
               w_wait_nxt   = '0;
               w_starve_nxt = '0;
            end
         end

         ST_GNT_IF, ST_GNT_D: begin
            // An ack in the last allowed cycle still wins over the timeout.
            if (mem_ack || (r_wait_cnt == c_WAIT_LAST)) begin
               w_state_nxt = ST_IDLE;
               w_req_nxt   = 1'b0;
               w_we_nxt    = 1'b0;
               w_err_nxt   = ~mem_ack;
               if (r_state == ST_GNT_IF) begin
                  w_if_valid_nxt = 1'b1;
                  w_if_rdata_nxt = mem_ack ? mem_rdata : '0;
               end else begin
                  w_d_valid_nxt = 1'b1;
                  w_d_rdata_nxt = (mem_ack && !mem_we) ? mem_rdata : '0;
               end
            end else begin
               w_wait_nxt = r_wait_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench for the IF/MEM memory port arbiter
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } d_exp_t;

   logic        clk = 1'b0;
   logic        rst, if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, err;
   logic        mem_ack;

   logic        auto_ack = 1'b0;
   logic        man_ack  = 1'b0;
   bit          resp_en  = 1'b1;
   bit          use_pat  = 1'b0;
   int          ack_delay = 0;
   int          resp_wait = 0;
   logic [31:0] rdata_val = 32'h0;

   int          n_cmp  = 0;
   int          n_fail = 0;

   logic [31:0] exp_if_q[$];
   d_exp_t      exp_d_q[$];
   bit          exp_grant_q[$];

   always #5 clk = ~clk;

   assign mem_ack   = resp_en ? auto_ack : man_ack;
   assign mem_rdata = use_pat ? ~mem_addr : rdata_val;

   // Memory model: acks in the (ack_delay+1)-th cycle of mem_req; -1 never acks.
   always @(negedge clk) begin
      if (!mem_req) begin
         resp_wait = 0;
         auto_ack  = 1'b0;
      end else begin
         auto_ack  = (ack_delay >= 0) && (resp_wait == ack_delay);
         resp_wait = resp_wait + 1;
      end
   end

   mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .err(err)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (2) tick();
      #1;
      n_cmp++;
      if ({mem_req, mem_we, if_valid, d_valid, err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_valid, d_valid, err});
      end
      n_cmp++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata);
      end
      n_cmp++;
      if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata);
      end
      n_cmp++;
      if (dut.r_starve_cnt !== 3'd0) begin
         n_fail++; $display("FAIL reset_starve: got %0d expected 0", dut.r_starve_cnt);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_fetch();
      int  req_cyc = 0, stall_cyc = 0, dv = 0, extra = 0;
      bit  done = 0, bus_bad = 0;
      logic [31:0] e;
      use_pat = 0; rdata_val = 32'h2008_0005; ack_delay = 1;
      tick();
      if_req = 1'b1; if_addr = 32'h0000_0040;
      exp_if_q.push_back(32'h2008_0005);
      for (int cyc = 0; cyc < 30; cyc++) begin
         #1;
         if (mem_req) begin
            req_cyc++;
            if (mem_we !== 1'b0 || mem_addr !== 32'h40) bus_bad = 1;
         end
         if (if_stall) stall_cyc++;
         if (d_valid) dv++;
         if (if_valid) begin
            done = 1;
            e = exp_if_q.pop_front();
            n_cmp++;
            if (if_rdata !== e) begin
               n_fail++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, e);
            end
            break;
         end
         tick();
      end
      n_cmp++;
      if (!done) begin n_fail++; $display("FAIL fetch_timeout: got no if_valid expected one within 30 cycles"); end
      n_cmp++;
      if (req_cyc != 2) begin n_fail++; $display("FAIL fetch_req_cycles: got %0d expected 2", req_cyc); end
      n_cmp++;
      if (bus_bad) begin n_fail++; $display("FAIL fetch_bus: got we/addr wrong expected we=0 addr=40"); end
      n_cmp++;
      if (stall_cyc != 3) begin n_fail++; $display("FAIL fetch_stall_cycles: got %0d expected 3", stall_cyc); end
      n_cmp++;
      if (dv != 0) begin n_fail++; $display("FAIL fetch_d_valid: got %0d expected 0", dv); end
      tick();
      if_req = 1'b0;
      repeat (4) begin
         tick(); #1;
         if (mem_req || if_valid || if_stall) extra++;
      end
      n_cmp++;
      if (extra != 0) begin n_fail++; $display("FAIL fetch_regrant: got %0d busy cycles expected 0", extra); end
   endtask

   task automatic test_store();
      int     vcyc = -1, iv = 0;
      bit     bus_bad = 0;
      d_exp_t e;
      use_pat = 0; rdata_val = 32'h1234_5678; ack_delay = 0;
      tick();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      exp_d_q.push_back('{rdata: 32'h0, err: 1'b0});
      for (int cyc = 0; cyc < 30; cyc++) begin
         #1;
         if (mem_req && (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h100))
            bus_bad = 1;
         if (if_valid) iv++;
         if (d_valid) begin
            vcyc = cyc;
            e = exp_d_q.pop_front();
            n_cmp++;
            if (d_rdata !== e.rdata || err !== e.err) begin
               n_fail++; $display("FAIL store_result: got rdata=%h err=%b expected rdata=%h err=%b", d_rdata, err, e.rdata, e.err);
            end
            break;
         end
         tick();
      end
      n_cmp++;
      if (vcyc != 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", vcyc); end
      n_cmp++;
      if (bus_bad) begin n_fail++; $display("FAIL store_bus: got wrong we/wdata/addr expected 1/DEADBEEF/100"); end
      n_cmp++;
      if (iv != 0) begin n_fail++; $display("FAIL store_if_valid: got %0d expected 0", iv); end
      tick();
      d_req = 1'b0; d_we = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      int          starve_m = 0, vcount = 0;
      bit          prev_req = 0, owner_d, exp_owner;
      logic [31:0] ei;
      d_exp_t      ed;
      use_pat = 1; ack_delay = 0;
      exp_grant_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      if_req = 1'b1; if_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      for (int cyc = 0; cyc < 80 && vcount < 6; cyc++) begin
         #1;
         if (mem_req && !prev_req) begin
            owner_d = (mem_addr == 32'h300);
            n_cmp++;
            if (exp_grant_q.size() == 0) begin
               n_fail++; $display("FAIL cont_extra_grant: got grant owner_d=%b expected none", owner_d);
            end else begin
               exp_owner = exp_grant_q.pop_front();
               if (owner_d !== exp_owner) begin
                  n_fail++; $display("FAIL cont_grant_order: got owner_d=%b expected %b", owner_d, exp_owner);
               end
               if (exp_owner) begin
                  if (starve_m < 4) starve_m++;
                  exp_d_q.push_back('{rdata: ~32'h300, err: 1'b0});
               end else begin
                  starve_m = 0;
                  exp_if_q.push_back(~32'h200);
               end
               n_cmp++;
               if (dut.r_starve_cnt !== 3'(starve_m)) begin
                  n_fail++; $display("FAIL cont_starve: got %0d expected %0d", dut.r_starve_cnt, starve_m);
               end
            end
         end
         prev_req = mem_req;
         if (d_valid) begin
            vcount++;
            n_cmp++;
            if (exp_d_q.size() == 0) begin
               n_fail++; $display("FAIL cont_d_unexpected: got d_valid expected none");
            end else begin
               ed = exp_d_q.pop_front();
               if (d_rdata !== ed.rdata) begin
                  n_fail++; $display("FAIL cont_d_rdata: got %h expected %h", d_rdata, ed.rdata);
               end
            end
         end
         if (if_valid) begin
            vcount++;
            n_cmp++;
            if (exp_if_q.size() == 0) begin
               n_fail++; $display("FAIL cont_if_unexpected: got if_valid expected none");
            end else begin
               ei = exp_if_q.pop_front();
               if (if_rdata !== ei) begin
                  n_fail++; $display("FAIL cont_if_rdata: got %h expected %h", if_rdata, ei);
               end
            end
         end
         if (vcount < 6) tick();
      end
      n_cmp++;
      if (vcount != 6 || exp_grant_q.size() != 0) begin
         n_fail++; $display("FAIL cont_completions: got %0d valids, %0d grants pending expected 6/0", vcount, exp_grant_q.size());
      end
      tick();
      if_req = 1'b0; d_req = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int     req_cyc = 0, err_cyc = 0, extra = 0;
      bit     done = 0;
      d_exp_t e;
      use_pat = 0; rdata_val = 32'hFFFF_FFFF; ack_delay = -1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      exp_d_q.push_back('{rdata: 32'h0, err: 1'b1});
      for (int cyc = 0; cyc < 40; cyc++) begin
         #1;
         if (mem_req) req_cyc++;
         if (err) err_cyc++;
         if (d_valid) begin
            done = 1;
            e = exp_d_q.pop_front();
            n_cmp++;
            if (d_rdata !== e.rdata || err !== e.err) begin
               n_fail++; $display("FAIL timeout_result: got rdata=%h err=%b expected rdata=%h err=%b", d_rdata, err, e.rdata, e.err);
            end
            break;
         end
         tick();
      end
      n_cmp++;
      if (!done) begin n_fail++; $display("FAIL timeout_no_valid: got no d_valid expected one within 40 cycles"); end
      n_cmp++;
      if (req_cyc != 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 16", req_cyc); end
      tick();
      d_req = 1'b0;
      repeat (3) begin
         tick(); #1;
         if (mem_req || err || d_valid) extra++;
      end
      n_cmp++;
      if (err_cyc != 1 || extra != 0) begin
         n_fail++; $display("FAIL timeout_idle: got err_cycles=%0d busy=%0d expected 1/0", err_cyc, extra);
      end
   endtask

   task automatic test_reset_mid_access();
      int req_cyc = 0, stray = 0;
      resp_en = 0; man_ack = 1'b0; ack_delay = -1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (mem_req) req_cyc++;
         if (req_cyc == 3) break;
         tick();
      end
      rst = 1'b1; d_req = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (req_cyc != 3 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_req_drop: got req_cycles=%0d mem_req=%b expected 3/0", req_cyc, mem_req);
      end
      n_cmp++;
      if (dut.r_starve_cnt !== 3'd0) begin
         n_fail++; $display("FAIL rstmid_starve: got %0d expected 0", dut.r_starve_cnt);
      end
      tick();
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      repeat (4) begin
         #1;
         if (if_valid || d_valid || err || mem_req) stray++;
         tick();
      end
      n_cmp++;
      if (stray != 0) begin n_fail++; $display("FAIL rstmid_stray_ack: got %0d active cycles expected 0", stray); end
      resp_en = 1;
   endtask

   task automatic test_late_ack();
      int     req_cyc = 0, err_cyc = 0;
      bit     done = 0;
      d_exp_t e;
      use_pat = 0; rdata_val = 32'hCAFE_F00D; ack_delay = 15;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
      exp_d_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
      for (int cyc = 0; cyc < 40; cyc++) begin
         #1;
         if (mem_req) req_cyc++;
         if (err) err_cyc++;
         if (d_valid) begin
            done = 1;
            e = exp_d_q.pop_front();
            n_cmp++;
            if (d_rdata !== e.rdata || err !== e.err) begin
               n_fail++; $display("FAIL late_ack_result: got rdata=%h err=%b expected rdata=%h err=%b", d_rdata, err, e.rdata, e.err);
            end
            break;
         end
         tick();
      end
      n_cmp++;
      if (!done || req_cyc != 16 || err_cyc != 0) begin
         n_fail++; $display("FAIL late_ack_timing: got done=%b req_cycles=%0d err_cycles=%0d expected 1/16/0", done, req_cyc, err_cyc);
      end
      tick();
      d_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_contention();
      test_timeout();
      test_reset_mid_access();
      test_late_ack();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
